// File: rtl/commit_free_queue_if.sv
// commit_free_queue_if: commit-side and freelist-side signals of the
// commit free queue. The queue uses the slave modport. The commit stage and
// the freelist, or a testbench standing in for them, use the master modport.
interface commit_free_queue_if #(
  parameter int PREG_IDX_WIDTH = 6,
  parameter int LOG_DEPTH      = 3
);
  logic                      commit0_valid;
  logic                      commit0_rd_wen;
  logic [PREG_IDX_WIDTH-1:0] commit0_old_preg;
  logic                      commit1_valid;
  logic                      commit1_rd_wen;
  logic [PREG_IDX_WIDTH-1:0] commit1_old_preg;
  logic                      commit_ready;
  logic                      free_stall;
  logic                      write0_valid;
  logic [PREG_IDX_WIDTH-1:0] write0_data;
  logic                      write1_valid;
  logic [PREG_IDX_WIDTH-1:0] write1_data;
  logic [LOG_DEPTH:0]        occupancy;

  modport master (
    output commit0_valid, commit0_rd_wen, commit0_old_preg,
    output commit1_valid, commit1_rd_wen, commit1_old_preg,
    output free_stall,
    input  commit_ready, write0_valid, write0_data,
    input  write1_valid, write1_data, occupancy
  );

  modport slave (
    input  commit0_valid, commit0_rd_wen, commit0_old_preg,
    input  commit1_valid, commit1_rd_wen, commit1_old_preg,
    input  free_stall,
    output commit_ready, write0_valid, write0_data,
    output write1_valid, write1_data, occupancy
  );
endinterface

// File: rtl/commit_free_queue.sv
// commit_free_queue: a buffer that returns the old physical registers of
// retiring instructions to the rename freelist.
// Each cycle the commit stage can retire up to two instructions. The block
// keeps only the old pregs of instructions that wrote a destination. It packs
// those pregs in age order into a circular FIFO. It then drains the FIFO in
// order onto the two free ports of the freelist.
// Optional feature: define COMMIT_FREE_BYPASS_EN to enable the bypass. With
// the bypass, frees skip the FIFO while it is empty and unstalled, and they
// appear on the free ports in the same cycle.
module commit_free_queue #(
  parameter int PREG_IDX_WIDTH = 6,
  parameter int DEPTH          = 8,
  parameter int LOG_DEPTH      = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  commit_free_queue_if.slave bus
);

  localparam int PTR_W = LOG_DEPTH + 1;

  typedef logic [PREG_IDX_WIDTH-1:0] preg_t;
  typedef logic [LOG_DEPTH-1:0]      idx_t;
  typedef logic [PTR_W-1:0]          ptr_t;

  // The pointers carry one extra wrap bit, so a full FIFO and an empty FIFO
  // have different pointer values.
  ptr_t  head_reg, tail_reg;
  ptr_t  head_next, tail_next;
  ptr_t  occ;
  preg_t mem [DEPTH];

  logic  ready;
  logic  free0, free1;
  logic  first_valid, second_valid;
  preg_t first_data, second_data;
  idx_t  head_idx, head_idx1, tail_idx, tail_idx1;
  logic  pop0, pop1;
  logic  push_en, push0, push1;
  ptr_t  n_push, n_pop;

  // commit_ready is computed only from the pointer registers, so free_stall
  // and the commit inputs have no combinational path to it.
  assign occ   = tail_reg - head_reg;
  assign ready = (occ <= ptr_t'(DEPTH - 2));

  assign bus.occupancy    = occ;
  assign bus.commit_ready = ready;

  // A slot frees its old preg only if it wrote a destination and the queue
  // accepted the commit. Commits made while the queue is not ready are lost.
  assign free0 = bus.commit0_valid & bus.commit0_rd_wen & ready;
  assign free1 = bus.commit1_valid & bus.commit1_rd_wen & ready;

  // Pack the frees in age order. A slot-1 free that arrives alone takes the
  // first position.
  always_comb begin
    first_valid  = free0 | free1;
    second_valid = free0 & free1;
    first_data   = free0 ? bus.commit0_old_preg : bus.commit1_old_preg;
    second_data  = bus.commit1_old_preg;
  end

  assign head_idx  = head_reg[LOG_DEPTH-1:0];
  assign head_idx1 = head_idx + idx_t'(1);
  assign tail_idx  = tail_reg[LOG_DEPTH-1:0];
  assign tail_idx1 = tail_idx + idx_t'(1);

  // While the freelist is not stalled, the FIFO presents its oldest one or
  // two entries.
  assign pop0 = !bus.free_stall && (occ != '0);
  assign pop1 = !bus.free_stall && (occ >= ptr_t'(2));

  // Select what drives the free ports and whether the new frees are written
  // into the FIFO.
  always_comb begin
    bus.write0_valid = 1'b0;
    bus.write0_data  = '0;
    bus.write1_valid = 1'b0;
    bus.write1_data  = '0;
    push_en          = 1'b1;
`ifdef COMMIT_FREE_BYPASS_EN
    if ((occ == '0) && !bus.free_stall) begin
      // The FIFO is empty and unstalled, so the new frees cannot overtake
      // any older entry. Send them straight to the free ports.
      push_en          = 1'b0;
      bus.write0_valid = first_valid;
      bus.write0_data  = first_valid ? first_data : '0;
      bus.write1_valid = second_valid;
      bus.write1_data  = second_valid ? second_data : '0;
    end else begin
      bus.write0_valid = pop0;
      bus.write0_data  = pop0 ? mem[head_idx] : '0;
      bus.write1_valid = pop1;
      bus.write1_data  = pop1 ? mem[head_idx1] : '0;
    end
`else
    bus.write0_valid = pop0;
    bus.write0_data  = pop0 ? mem[head_idx] : '0;
    bus.write1_valid = pop1;
    bus.write1_data  = pop1 ? mem[head_idx1] : '0;
`endif
  end

  assign push0 = push_en & first_valid;
  assign push1 = push_en & second_valid;

  assign n_push    = ptr_t'(push0) + ptr_t'(push1);
  assign n_pop     = ptr_t'(pop0) + ptr_t'(pop1);
  assign tail_next = tail_reg + n_push;
  assign head_next = head_reg + n_pop;

  // Pointer registers. Reset empties the FIFO and discards any buffered
  // entries.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  // Entry storage. The array needs no reset because the pointers decide
  // which entries are live.
  always_ff @(posedge clock) begin
    if (push0) mem[tail_idx]  <= first_data;
    if (push1) mem[tail_idx1] <= second_data;
  end

endmodule

// File: tb/tb_commit_free_queue.sv
// tb_commit_free_queue: directed self-checking bench for commit_free_queue.
// Expected values match the default build. The COMMIT_FREE_BYPASS_EN
// branches hold the expected values for the bypass build.
module tb_commit_free_queue;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  commit_free_queue_if #(.PREG_IDX_WIDTH(6), .LOG_DEPTH(3)) bus ();

  commit_free_queue #(.PREG_IDX_WIDTH(6), .DEPTH(8), .LOG_DEPTH(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ports(input string tag, input bit v0, input int d0, input bit v1, input int d1);
    check({tag, ".w0v"}, 32'(bus.write0_valid), 32'(v0));
    check({tag, ".w0d"}, 32'(bus.write0_data),  32'(d0));
    check({tag, ".w1v"}, 32'(bus.write1_valid), 32'(v1));
    check({tag, ".w1d"}, 32'(bus.write1_data),  32'(d1));
  endtask

  task automatic status(input string tag, input int occ, input bit rdy);
    check({tag, ".occ"}, 32'(bus.occupancy),    32'(occ));
    check({tag, ".rdy"}, 32'(bus.commit_ready), 32'(rdy));
  endtask

  task automatic drive(input bit v0, input bit w0, input int p0,
                       input bit v1, input bit w1, input int p1, input bit s);
    bus.commit0_valid    = v0;
    bus.commit0_rd_wen   = w0;
    bus.commit0_old_preg = 6'(p0);
    bus.commit1_valid    = v1;
    bus.commit1_rd_wen   = w1;
    bus.commit1_old_preg = 6'(p1);
    bus.free_stall       = s;
    #1;
  endtask

  task automatic idle(input bit s);
    drive(0, 0, 0, 0, 0, 0, s);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    $display("[%0t] occ=%0d rdy=%0b w0=%0b/%0d w1=%0b/%0d", $time, bus.occupancy,
             bus.commit_ready, bus.write0_valid, bus.write0_data,
             bus.write1_valid, bus.write1_data);
  endtask

  initial begin
    int q[$];
    logic [11:0] stall_pat;
    bit s, rdy_e, byp;
    bit ev0, ev1;
    int ed0, ed1, a, b;

    // Reset state
    idle(0);
    tick();
    tick();
    status("reset", 0, 1);
    ports("reset", 0, 0, 0, 0);
    reset_n = 1'b1;

    // Two frees (40, 41) retired in one cycle
    drive(1, 1, 40, 1, 1, 41, 0);
`ifdef COMMIT_FREE_BYPASS_EN
    ports("pair.c1", 1, 40, 1, 41);
    tick();
    idle(0);
    status("pair.c2", 0, 1);
    ports("pair.c2", 0, 0, 0, 0);
`else
    ports("pair.c1", 0, 0, 0, 0);
    tick();
    idle(0);
    status("pair.c2", 2, 1);
    ports("pair.c2", 1, 40, 1, 41);
    tick();
    status("pair.c3", 0, 1);
    ports("pair.c3", 0, 0, 0, 0);
`endif

    // Only slot 1 wrote a destination: one free, preg 7
    drive(1, 0, 9, 1, 1, 7, 0);
`ifdef COMMIT_FREE_BYPASS_EN
    ports("lone1.c1", 1, 7, 0, 0);
    tick();
    idle(0);
    status("lone1.c2", 0, 1);
`else
    ports("lone1.c1", 0, 0, 0, 0);
    tick();
    idle(0);
    status("lone1.c2", 1, 1);
    ports("lone1.c2", 1, 7, 0, 0);
    tick();
    status("lone1.c3", 0, 1);
`endif

    // Fill while stalled: 32..37, then 38 (occupancy 7), then a dropped commit
    drive(1, 1, 32, 1, 1, 33, 1);
    ports("stall.in", 0, 0, 0, 0);
    tick();
    status("stall.2", 2, 1);
    drive(1, 1, 34, 1, 1, 35, 1);
    tick();
    status("stall.4", 4, 1);
    drive(1, 1, 36, 1, 1, 37, 1);
    tick();
    status("stall.6", 6, 1);
    drive(1, 1, 38, 0, 0, 0, 1);
    tick();
    status("stall.7", 7, 0);
    drive(1, 1, 39, 1, 1, 60, 1);
    ports("stall.drop", 0, 0, 0, 0);
    tick();
    status("stall.dropped", 7, 0);
    idle(0);
    ports("drain.1", 1, 32, 1, 33);
    tick();
    status("drain.1", 5, 1);
    ports("drain.2", 1, 34, 1, 35);
    tick();
    status("drain.2", 3, 1);
    ports("drain.3", 1, 36, 1, 37);
    tick();
    status("drain.3", 1, 1);
    ports("drain.4", 1, 38, 0, 0);
    tick();
    status("drain.4", 0, 1);
    ports("drain.5", 0, 0, 0, 0);

    // Wrap: two pushes per cycle with a fixed stall pattern, checked against a queue model
    stall_pat = 12'b0001_1100_0110;
    for (int i = 0; i < 18; i++) begin
      s = (i < 12) ? stall_pat[i] : 1'b0;
      a = 2 * i + 1;
      b = 2 * i + 2;
      if (i < 12) drive(1, 1, a, 1, 1, b, s);
      else        idle(0);
      rdy_e = (q.size() <= 6);
      status($sformatf("wrap%0d", i), q.size(), rdy_e);
      byp = 0;
      ev0 = 0; ed0 = 0; ev1 = 0; ed1 = 0;
`ifdef COMMIT_FREE_BYPASS_EN
      if (q.size() == 0 && !s && i < 12) begin
        byp = 1;
        ev0 = 1; ed0 = a; ev1 = 1; ed1 = b;
      end
`endif
      if (!byp && !s) begin
        if (q.size() >= 1) begin ev0 = 1; ed0 = q[0]; end
        if (q.size() >= 2) begin ev1 = 1; ed1 = q[1]; end
      end
      ports($sformatf("wrap%0d", i), ev0, ed0, ev1, ed1);
      if (ev0 && !byp) void'(q.pop_front());
      if (ev1 && !byp) void'(q.pop_front());
      if (i < 12 && rdy_e && !byp) begin
        q.push_back(a);
        q.push_back(b);
      end
      tick();
    end
    idle(0);
    status("wrap.end", 0, 1);

    // occupancy 1 (preg 50) plus two new frees (51, 52) in an unstalled cycle
    drive(1, 1, 50, 0, 0, 0, 1);
    tick();
    status("mix.hold", 1, 1);
    drive(1, 1, 51, 1, 1, 52, 0);
    ports("mix.N", 1, 50, 0, 0);
    tick();
    idle(0);
    status("mix.N1", 2, 1);
    ports("mix.N1", 1, 51, 1, 52);
    tick();
    status("mix.N2", 0, 1);

    // Reset with five entries buffered
    drive(1, 1, 2, 1, 1, 3, 1);
    tick();
    drive(1, 1, 4, 1, 1, 5, 1);
    tick();
    drive(1, 1, 6, 0, 0, 0, 1);
    tick();
    status("rst.pre", 5, 1);
    reset_n = 1'b0;
    idle(0);
    tick();
    status("rst.mid", 0, 1);
    ports("rst.mid", 0, 0, 0, 0);
    reset_n = 1'b1;
    idle(0);
    tick();
    status("rst.post", 0, 1);
    ports("rst.post", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
